// File: rtl/register_file_pkg.sv
// Shared defaults and helpers for the general-purpose register bank.
package register_file_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 16;
    localparam int unsigned DEFAULT_DEPTH    = 8;
    localparam bit          DEFAULT_ZERO_REG = 1'b1;
    localparam bit          DEFAULT_BYPASS   = 1'b1;

    // DEPTH need not be a power of two, so the top address codes may be unmapped.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/register_cell.sv
// One storage word plus its "written since reset" flag.
module register_cell
    import register_file_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             written
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            written <= 1'b0;
        end else if (enable) begin
            q       <= d;
            written <= 1'b1;
        end
    end

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register bank: one synchronous write port, two combinational
// read ports, optional hard-wired zero word and write-to-read bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter bit          ZERO_REG = DEFAULT_ZERO_REG,
    parameter bit          BYPASS   = DEFAULT_BYPASS,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rvalid_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_b
);

    logic [WIDTH-1:0]  words [DEPTH];
    logic [DEPTH-1:0]  flags;
    logic              write_ok;
    logic [ADDR_W-1:0] raddr [2];

    // reset is folded in so the bypass path also sees a dropped write.
    assign write_ok = we && !reset
                      && addr_in_range(32'(waddr), DEPTH)
                      && !(ZERO_REG && (waddr == '0));

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        register_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .enable  (write_ok && (waddr == ADDR_W'(i))),
            .d       (wdata),
            .q       (words[i]),
            .written (flags[i])
        );
    end

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;

    for (genvar p = 0; p < 2; p++) begin : g_read
        logic [WIDTH-1:0] data;
        logic             valid;

        // Priority: zero word, then in-flight write, then stored word.
        always_comb begin
            data  = '0;
            valid = 1'b0;
            if (ZERO_REG && (raddr[p] == '0)) begin
                valid = 1'b1;
            end else if (BYPASS && write_ok && (raddr[p] == waddr)) begin
                data  = wdata;
                valid = 1'b1;
            end else if (addr_in_range(32'(raddr[p]), DEPTH)) begin
                data  = words[raddr[p]];
                valid = flags[raddr[p]];
            end
        end
    end

    assign rdata_a  = g_read[0].data;
    assign rvalid_a = g_read[0].valid;
    assign rdata_b  = g_read[1].data;
    assign rvalid_b = g_read[1].valid;

endmodule
